// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared APB definitions: transfer-phase state encoding and the
//            default address/data widths used by masters and completers.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/apb_master_wdog.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_wdog
// Purpose  : ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the
//            TIMEOUT_CYCLES-th one if PREADY is still low.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic pready,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // In the k-th ACCESS cycle the counter holds k-1.
  assign expire = active & ~pready & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !pready && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : APB requester: runs single-beat valid/ready commands as APB
//            transfers and returns a one-cycle response pulse.
//            Optional watchdog abort: define APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              wd_expire;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (PCLK),
    .rst    (PRESET),
    .start  (state_q == SETUP),
    .active (state_q == ACCESS),
    .pready (PREADY),
    .expire (wd_expire)
  );
`else
  // No watchdog: constant 0 for every legal TIMEOUT_CYCLES (>= 2).
  assign wd_expire = (TIMEOUT_CYCLES == 0);
`endif

  // Bus controls decode straight from state so an async reset drops them at once.
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign cmd_ready   = (state_q == IDLE) & ~PRESET;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (wd_expire) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Randomized scoreboard bench for apb_master with a completer model.
//            Timeout cases follow APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int T    = 16;
  localparam int HANG = 1000;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] rdata; logic timeout; int cyc; } exp_t;
  typedef struct { logic write; logic [7:0] addr; logic [7:0] wdata; } bus_t;

  exp_t       exp_q[$];
  bus_t       bus_q[$];
  int         wait_q[$];
  logic [7:0] ref_mem[256];
  logic [7:0] cpl_mem[256];
  int         last_done = 0;
  bit         noise_en = 1'b1;

  // Completer model: per-transfer wait count, own memory, random PREADY noise outside ACCESS.
  int wait_left = 0;
  bit stable_ok = 1'b1;
  always @(negedge PCLK) begin
    if (PSEL && bus_q.size() > 0) begin
      if (PADDR !== bus_q[0].addr || PWRITE !== bus_q[0].write ||
          (bus_q[0].write && PWDATA !== bus_q[0].wdata))
        stable_ok = 1'b0;
    end
    if (PSEL && !PENABLE) begin
      wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      PREADY    = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      PRDATA    = 8'($urandom);
    end else if (PSEL && PENABLE) begin
      if (wait_left == 0) begin
        PREADY = 1'b1;
        if (bus_q.size() > 0) begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_stable", {31'd0, stable_ok}, 32'd1);
          chk("bus_addr", {24'd0, PADDR}, {24'd0, b.addr});
          chk("bus_write", {31'd0, PWRITE}, {31'd0, b.write});
          if (b.write) chk("bus_wdata", {24'd0, PWDATA}, {24'd0, b.wdata});
        end
        stable_ok = 1'b1;
        if (PWRITE) begin
          cpl_mem[PADDR] = PWDATA;
          PRDATA = 8'($urandom);
        end else begin
          PRDATA = cpl_mem[PADDR];
        end
      end else begin
        wait_left--;
        PREADY = 1'b0;
        PRDATA = 8'($urandom);
      end
    end else begin
      PREADY = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      PRDATA = 8'($urandom);
    end
  end

  // Response monitor / scoreboard.
  bit         prev_rsp = 1'b0, prev_ack = 1'b0;
  logic [7:0] last_rdata = 8'h00;
  always begin
    @(negedge PCLK);
    #2;
    if (PRESET) begin
      prev_rsp   = 1'b0;
      prev_ack   = 1'b0;
      last_rdata = 8'h00;
    end else begin
      if (prev_rsp) begin
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rdata});
      end
      if (prev_ack) chk("psel_gap", {31'd0, PSEL}, 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%0h, required no response", rsp_rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
          chk("rsp_cycle", cyc, e.cyc);
        end
        last_rdata = rsp_rdata;
      end
      prev_rsp = rsp_valid;
      prev_ack = PSEL && PENABLE && PREADY;
    end
  end

  // Reference model: a transfer accepted at edge N completes at N+2+waits,
  // or aborts at N+1+T when the watchdog is built and waits >= T.
  task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                       input int waits, input bit b2b, input bit track);
    int   n;
    int   acc;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    n = 0;
    while (!cmd_ready) begin
      @(negedge PCLK);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    if (b2b) chk("b2b_accept", acc, last_done + 1);
    wait_q.push_back(waits);
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= T) begin
      e = '{8'h00, 1'b1, acc + 1 + T};
      exp_q.push_back(e);
      last_done = e.cyc;
    end else
`endif
    if (waits < HANG) begin
      e = '{(wr ? 8'h00 : ref_mem[addr]), 1'b0, acc + 2 + waits};
      exp_q.push_back(e);
      last_done = e.cyc;
      if (wr) ref_mem[addr] = data;
      if (track) bus_q.push_back('{wr, addr, data});
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge PCLK);
      n++;
    end
    repeat (2) @(negedge PCLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    PRESET = 1'b1;
    #1;
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    exp_q.delete();
    bus_q.delete();
    wait_q.delete();
    @(negedge PCLK);
    #1;
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    bit b2b;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      cpl_mem[i] = 8'h00;
    end
    cmd_valid = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("reset_psel", {31'd0, PSEL}, 32'd0);
    chk("reset_penable", {31'd0, PENABLE}, 32'd0);
    chk("reset_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("reset_paddr", {24'd0, PADDR}, 32'd0);
    chk("reset_pwdata", {24'd0, PWDATA}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("reset_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    // Directed: zero-wait write, 3-wait read, back-to-back write/read.
    issue(1'b1, 8'h05, 8'hA5, 0, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    drain();
    issue(1'b1, 8'h10, 8'h3C, 1, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    drain();
    issue(1'b0, 8'h10, 8'h00, 3, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    drain();
    issue(1'b1, 8'h01, 8'h96, 0, 1'b0, 1'b1);
    issue(1'b0, 8'h01, 8'h00, 0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    drain();

    // Randomized traffic over a small address window so reads hit prior writes.
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 4), b2b, 1'b1);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) begin
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge PCLK);
        #1;
      end
    end
    cmd_valid = 1'b0;
    drain();

    // Asynchronous reset during an ACCESS wait state, then a normal read.
    issue(1'b0, 8'h20, 8'h00, HANG, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    repeat (4) @(negedge PCLK);
    #1;
    pulse_reset();
    issue(1'b0, 8'h05, 8'h00, 1, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 8'h30, 8'h00, HANG, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    drain();
    issue(1'b0, 8'h05, 8'h00, T - 1, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    drain();
`else
    issue(1'b0, 8'h31, 8'h00, HANG, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    repeat (100) @(negedge PCLK);
    #1;
    chk("hang_psel", {31'd0, PSEL}, 32'd1);
    chk("hang_penable", {31'd0, PENABLE}, 32'd1);
    chk("hang_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    pulse_reset();
`endif
    issue(1'b1, 8'h22, 8'h5A, 2, 1'b0, 1'b1);
    issue(1'b0, 8'h22, 8'h00, 0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
